// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: word/instruction types, op kinds, FSM states.
// Optional build macro PC_MISALIGN_TRAP_EN selects trap-on-misaligned-target behaviour.
package pc_sequencer_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [31:0]     instruction_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_kind_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_TRAP     = 2'd2
    } pc_state_t;

    // Resolved control-flow op as delivered by the branch comparator.
    typedef struct packed {
        pc_kind_t kind;
        word_t    pc;
        word_t    imm;
        word_t    rs1;
        logic     taken;
    } pc_op_t;

endpackage

// File: rtl/pc_sequencer_target_gen.sv
// Combinational next-PC generation for one resolved op.
// With PC_MISALIGN_TRAP_EN the raw target is kept and misalignment flagged; otherwise bits [1:0] are cleared.
module pc_target_gen
    import pc_sequencer_pkg::*;
(
    input  pc_op_t op,
    output word_t  nxt,
    output word_t  seq,
    output logic   misaligned
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam word_t ALIGN_MASK = '1;
`else
    localparam word_t ALIGN_MASK = ~word_t'(3);
`endif

    word_t raw;

    always_comb begin
        seq = op.pc + word_t'(INSTR_BYTES);
        raw = seq;
        unique case (op.kind)
            PC_SEQ:    raw = seq;
            PC_BRANCH: raw = op.taken ? (op.pc + op.imm) : seq;
            PC_JAL:    raw = op.pc + op.imm;
            PC_JALR:   raw = (op.rs1 + op.imm) & ~word_t'(1);
            default:   raw = seq;
        endcase
    end

    // Without the trap build the mask zeroes the low bits, so misaligned is constant 0.
    assign nxt        = raw & ALIGN_MASK;
    assign misaligned = |nxt[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Branch-resolution / PC-update stage: owns the architectural PC and issues held redirects to fetch.
// Build macro PC_MISALIGN_TRAP_EN enables the sticky misaligned-target trap (see pc_target_gen).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_rs1,
    input  logic             in_taken,
    output logic [31:0]      pc,
    output logic [31:0]      link_addr,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_target,
    output logic [CNT_W-1:0] redirect_count,
    output logic             trap
);

    pc_state_t        state_q, state_d;
    pc_op_t           op;
    word_t            nxt, seq;
    logic             misaligned;
    logic             accept, redirect_hs, needs_redirect;

    word_t            pc_d, target_d;
    logic             valid_d, trap_d, ready_d;
    logic [CNT_W-1:0] count_d;

    assign op = '{kind: pc_kind_t'(in_kind), pc: in_pc, imm: in_imm, rs1: in_rs1, taken: in_taken};

    pc_target_gen u_target_gen (
        .op         (op),
        .nxt        (nxt),
        .seq        (seq),
        .misaligned (misaligned)
    );

    assign link_addr      = seq;
    assign accept         = in_valid && in_ready;
    assign redirect_hs    = redirect_valid && redirect_ready;
    assign needs_redirect = (nxt != seq);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (misaligned)          state_d = ST_TRAP;
                    else if (needs_redirect) state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: if (redirect_hs) state_d = ST_RUN;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_RUN;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        pc_d     = pc;
        target_d = redirect_target;
        valid_d  = redirect_valid;
        count_d  = redirect_count;
        trap_d   = trap;
        ready_d  = (state_d == ST_RUN);
        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (misaligned) begin
                        trap_d = 1'b1;
                        pc_d   = in_pc;
                    end else begin
                        pc_d = nxt;
                        if (needs_redirect) begin
                            target_d = nxt;
                            valid_d  = 1'b1;
                        end
                    end
                end
            end
            ST_REDIRECT: begin
                if (redirect_hs) begin
                    valid_d = 1'b0;
                    count_d = redirect_count + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc              <= RESET_PC;
            redirect_target <= '0;
            redirect_valid  <= 1'b0;
            redirect_count  <= '0;
            trap            <= 1'b0;
            in_ready        <= 1'b1;
        end else begin
            pc              <= pc_d;
            redirect_target <= target_d;
            redirect_valid  <= valid_d;
            redirect_count  <= count_d;
            trap            <= trap_d;
            in_ready        <= ready_d;
        end
    end

endmodule
